// File: rtl/speed_key_ctrl.sv
// speed_key_ctrl
// Turns the two active-low board keys into single-cycle faster/slower step
// pulses for the 4-bit delay register. Each key is synchronised and
// debounced. An arbitration FSM lets exactly one key own the output at a
// time, auto-repeats while the owner key is held, and swallows any pulse
// that collides with a same-cycle bus write to the delay register.
//
// Output handshake: faster/slower are single-cycle request strobes with no
// backpressure. The delay register consumes them unconditionally in the
// cycle they are high and saturates on its own. A pulse that would coincide
// with write is dropped, not deferred.

module speed_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_faster_n,
    input  logic key_slower_n,
    input  logic write,
    output logic faster,
    output logic slower,
    output logic busy
);

    // Counter widths: one spare bit so the terminal value always fits.
    localparam int DBW     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW     = $clog2(RPT_MAX) + 1;

    localparam logic [DBW-1:0] DB_LAST     = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE      = DBW'(1);
    localparam logic [RPW-1:0] DELAY_LAST  = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] PERIOD_LAST = RPW'(REPEAT_PERIOD - 1);
    localparam logic [RPW-1:0] RPT_ONE     = RPW'(1);

    // IDLE    : no key owns the output
    // HOLD    : owner pressed, waiting out the initial repeat hold-off
    // REPEAT  : owner pressed, issuing periodic repeat pulses
    // RELEASE : owner let go while the other key was still down; wait for
    //           both keys up so the other key cannot silently take over
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Bit 0 = faster key, bit 1 = slower key. Level 1 = released.
    logic [1:0]     r_sync_meta;
    logic [1:0]     r_sync;
    logic [1:0]     r_stable;
    logic [DBW-1:0] r_db_cnt_f;
    logic [DBW-1:0] r_db_cnt_s;

    state_t         r_state;
    logic           r_owner_s;   // 0 = faster key owns, 1 = slower key owns
    logic [RPW-1:0] r_rpt_cnt;
    logic           r_pulse_f;
    logic           r_pulse_s;

    logic w_f_pressed;
    logic w_s_pressed;
    logic w_owner_pressed;
    logic w_other_pressed;

    assign w_f_pressed     = ~r_stable[0];
    assign w_s_pressed     = ~r_stable[1];
    assign w_owner_pressed = r_owner_s ? w_s_pressed : w_f_pressed;
    assign w_other_pressed = r_owner_s ? w_f_pressed : w_s_pressed;

    // Two-flop synchroniser for both raw keys; resets to released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= 2'b11;
            r_sync      <= 2'b11;
        end else begin
            r_sync_meta <= {key_slower_n, key_faster_n};
            r_sync      <= r_sync_meta;
        end
    end

    // Faster-key debouncer: accept a new level only after it has been
    // seen for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable[0] <= 1'b1;
            r_db_cnt_f  <= '0;
        end else if (r_sync[0] == r_stable[0]) begin
            r_db_cnt_f  <= '0;
        end else if (r_db_cnt_f == DB_LAST) begin
            r_stable[0] <= r_sync[0];
            r_db_cnt_f  <= '0;
        end else begin
            r_db_cnt_f  <= r_db_cnt_f + DB_ONE;
        end
    end

    // Slower-key debouncer, identical to the faster-key one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stable[1] <= 1'b1;
            r_db_cnt_s  <= '0;
        end else if (r_sync[1] == r_stable[1]) begin
            r_db_cnt_s  <= '0;
        end else if (r_db_cnt_s == DB_LAST) begin
            r_stable[1] <= r_sync[1];
            r_db_cnt_s  <= '0;
        end else begin
            r_db_cnt_s  <= r_db_cnt_s + DB_ONE;
        end
    end

    // Arbitration / auto-repeat FSM with registered step pulses. A release
    // is checked before the repeat terminal count, so a release in the same
    // cycle a repeat is due produces no pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner_s <= 1'b0;
            r_rpt_cnt <= '0;
            r_pulse_f <= 1'b0;
            r_pulse_s <= 1'b0;
        end else begin
            r_pulse_f <= 1'b0;
            r_pulse_s <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_rpt_cnt <= '0;
                    if (w_f_pressed) begin
                        r_owner_s <= 1'b0;
                        r_pulse_f <= 1'b1;
                        r_state   <= ST_HOLD;
                    end else if (w_s_pressed) begin
                        r_owner_s <= 1'b1;
                        r_pulse_s <= 1'b1;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!w_owner_pressed) begin
                        r_rpt_cnt <= '0;
                        r_state   <= w_other_pressed ? ST_RELEASE : ST_IDLE;
                    end else if (r_rpt_cnt == DELAY_LAST) begin
                        r_rpt_cnt <= '0;
                        r_pulse_f <= ~r_owner_s;
                        r_pulse_s <= r_owner_s;
                        r_state   <= ST_REPEAT;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + RPT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!w_owner_pressed) begin
                        r_rpt_cnt <= '0;
                        r_state   <= w_other_pressed ? ST_RELEASE : ST_IDLE;
                    end else if (r_rpt_cnt == PERIOD_LAST) begin
                        r_rpt_cnt <= '0;
                        r_pulse_f <= ~r_owner_s;
                        r_pulse_s <= r_owner_s;
                    end else begin
                        r_rpt_cnt <= r_rpt_cnt + RPT_ONE;
                    end
                end
                ST_RELEASE: begin
                    r_rpt_cnt <= '0;
                    if (!w_f_pressed && !w_s_pressed) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_rpt_cnt <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // A bus write in the cycle a pulse is presented wins; the step is lost.
    assign faster = r_pulse_f & ~write;
    assign slower = r_pulse_s & ~write;
    assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_speed_key_ctrl.sv
// Directed bench for speed_key_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Cycle numbering: a key change is driven just before
// edge 0; the value sampled after edge c-1 is "cycle c", so a clean press
// gives its first pulse in cycle 7.

module tb_speed_key_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic key_faster_n;
    logic key_slower_n;
    logic write;
    logic faster;
    logic slower;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    speed_key_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_faster_n(key_faster_n),
        .key_slower_n(key_slower_n),
        .write       (write),
        .faster      (faster),
        .slower      (slower),
        .busy        (busy)
    );

    // Clock
    always #5 clk = ~clk;

    // Release both keys and let the DUT return to idle.
    task automatic settle();
        key_faster_n = 1'b1;
        key_slower_n = 1'b1;
        write        = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        key_faster_n = 1'b1;
        key_slower_n = 1'b1;
        write        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (faster !== 1'b0) begin n_fail++; $display("FAIL reset faster got %0b exp 0", faster); end
        n_checks++;
        if (slower !== 1'b0) begin n_fail++; $display("FAIL reset slower got %0b exp 0", slower); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %0b exp 0", busy); end
        n_checks++;
        if (dut.r_state !== 2'd0) begin n_fail++; $display("FAIL reset state got %0d exp 0", dut.r_state); end
    endtask

    // Clean F press held 30 cycles: pulses at 7, then 17, 20, 23, 26, 29.
    task automatic test_press_hold();
        logic exp_f;
        key_faster_n = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            exp_f = (c == 7) || (c >= 17 && ((c - 17) % 3) == 0);
            n_checks++;
            if (faster !== exp_f) begin n_fail++; $display("FAIL press_hold faster c=%0d got %0b exp %0b", c, faster, exp_f); end
            n_checks++;
            if (slower !== 1'b0) begin n_fail++; $display("FAIL press_hold slower c=%0d got %0b exp 0", c, slower); end
            n_checks++;
            if (busy !== (c >= 7)) begin n_fail++; $display("FAIL press_hold busy c=%0d got %0b exp %0b", c, busy, (c >= 7)); end
        end
        settle();
        n_checks++;
        if (dut.r_state !== 2'd0) begin n_fail++; $display("FAIL press_hold idle_after state got %0d exp 0", dut.r_state); end
    endtask

    // Key toggling every 2 cycles never survives the 4-cycle debounce.
    task automatic test_bounce();
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            key_faster_n = (c < 20) ? logic'((c / 2) % 2) : 1'b1;
            #1;
            @(posedge clk);
            n_checks++;
            if (faster !== 1'b0) begin n_fail++; $display("FAIL bounce faster c=%0d got %0b exp 0", c, faster); end
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL bounce busy c=%0d got %0b exp 0", c, busy); end
        end
        settle();
    endtask

    // Short S press (released well before the repeat hold-off): one pulse.
    task automatic test_short_slower();
        logic exp_b;
        key_slower_n = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 8) key_slower_n = 1'b1;
            #1;
            exp_b = (c >= 7) && (c <= 14);
            n_checks++;
            if (slower !== (c == 7)) begin n_fail++; $display("FAIL short_slower slower c=%0d got %0b exp %0b", c, slower, (c == 7)); end
            n_checks++;
            if (faster !== 1'b0) begin n_fail++; $display("FAIL short_slower faster c=%0d got %0b exp 0", c, faster); end
            n_checks++;
            if (busy !== exp_b) begin n_fail++; $display("FAIL short_slower busy c=%0d got %0b exp %0b", c, busy, exp_b); end
        end
        n_checks++;
        if (dut.r_state !== 2'd0) begin n_fail++; $display("FAIL short_slower state got %0d exp 0", dut.r_state); end
        settle();
    endtask

    // Both keys on the same edge: F wins; dropping F with S held parks in
    // RELEASE with no slower pulse; dropping S returns to IDLE.
    task automatic test_both_keys();
        logic [1:0] exp_st;
        key_faster_n = 1'b0;
        key_slower_n = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 8)  key_faster_n = 1'b1;
            if (c == 20) key_slower_n = 1'b1;
            #1;
            if (c < 7)       exp_st = 2'd0;
            else if (c < 15) exp_st = 2'd1;
            else if (c < 27) exp_st = 2'd3;
            else             exp_st = 2'd0;
            n_checks++;
            if (faster !== (c == 7)) begin n_fail++; $display("FAIL both_keys faster c=%0d got %0b exp %0b", c, faster, (c == 7)); end
            n_checks++;
            if (slower !== 1'b0) begin n_fail++; $display("FAIL both_keys slower c=%0d got %0b exp 0", c, slower); end
            n_checks++;
            if (dut.r_state !== exp_st) begin n_fail++; $display("FAIL both_keys state c=%0d got %0d exp %0d", c, dut.r_state, exp_st); end
            n_checks++;
            if (busy !== (exp_st != 2'd0)) begin n_fail++; $display("FAIL both_keys busy c=%0d got %0b exp %0b", c, busy, (exp_st != 2'd0)); end
        end
        settle();
    endtask

    // A write during cycle 17 drops the first repeat; cycle 20 still pulses.
    task automatic test_write_suppress();
        logic exp_f;
        key_faster_n = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk);
            @(negedge clk);
            write = (c == 17);
            #1;
            exp_f = (c == 7) || (c == 20);
            n_checks++;
            if (faster !== exp_f) begin n_fail++; $display("FAIL write_suppress faster c=%0d got %0b exp %0b", c, faster, exp_f); end
        end
        write = 1'b0;
        settle();
    endtask

    // One-cycle reset during HOLD aborts; the still-held key re-debounces
    // and pulses again 7 cycles after reset is released.
    task automatic test_reset_mid_hold();
        key_faster_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (faster !== 1'b0) begin n_fail++; $display("FAIL reset_mid faster got %0b exp 0", faster); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy got %0b exp 0", busy); end
        n_checks++;
        if (dut.r_state !== 2'd0) begin n_fail++; $display("FAIL reset_mid state got %0d exp 0", dut.r_state); end
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            n_checks++;
            if (faster !== (c == 7)) begin n_fail++; $display("FAIL reset_mid repress faster c=%0d got %0b exp %0b", c, faster, (c == 7)); end
            n_checks++;
            if (busy !== (c >= 7)) begin n_fail++; $display("FAIL reset_mid repress busy c=%0d got %0b exp %0b", c, busy, (c >= 7)); end
        end
        settle();
    endtask

    initial begin
        reset        = 1'b1;
        key_faster_n = 1'b1;
        key_slower_n = 1'b1;
        write        = 1'b0;
        test_reset();
        test_press_hold();
        test_bounce();
        test_short_slower();
        test_both_keys();
        test_write_suppress();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
